mcp_datapath: RTL and testbench
===============================

Name: mcp_datapath

Overview:
- Multicycle MIPS datapath: the consumer of the multicycle controller's control word, and the producer of op/funct/zero back to it.
- Holds the architectural and inter-cycle state: PC, Instr, Data, A, B, ALUOut and the 32x32 register file.
- Contains the ALU and all datapath muxes.
- Sits between the controller and the unified instruction/data memory. memwrite goes directly from the controller to memory and does not enter this block.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
REGBITS, 5, register-file address width (2**REGBITS registers)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
pcen  input  1  PC load enable
irwrite  input  1  Instr register load enable
regwrite  input  1  register-file write enable
alusrca  input  1  ALU A select: 0 = PC, 1 = A
iord  input  1  address select: 0 = PC, 1 = ALUOut
memtoreg  input  1  write-back select: 0 = ALUOut, 1 = Data
regdst  input  1  write register select: 0 = Instr[20:16], 1 = Instr[15:11]
alusrcb  input  2  ALU B select
pcsrc  input  2  next-PC select
alucontrol  input  3  ALU operation
readdata  input  32  memory read data
op  output  6  Instr[31:26]
funct  output  6  Instr[5:0]
zero  output  1  ALUResult == 0 (combinational)
adr  output  32  memory address
writedata  output  32  B register, store data

Behaviour:
- Reset (reset = 0, asynchronous; takes effect immediately, including mid-instruction):
  - PC = PC_RESET.
  - Instr, Data, A, B, ALUOut and all register-file entries = 0.
  - Consequently op = 0, funct = 0, adr = PC_RESET, writedata = 0.
  - Deassertion is synchronous to clk by system design. No capture occurs on an edge where reset = 0.
- Registers on rising clk:
  - PC <= PCNext when pcen.
  - Instr <= readdata when irwrite.
  - Data <= readdata, unconditionally.
  - A <= RD1 and B <= RD2, unconditionally.
  - ALUOut <= ALUResult, unconditionally.
- Register file:
  - Reads are combinational: RD1 = reg[Instr[25:21]], RD2 = reg[Instr[20:16]].
  - Register 0 always reads 0. Writes to register 0 are discarded.
  - On a rising edge with regwrite, reg[WA] <= WD, where WA = regdst ? Instr[15:11] : Instr[20:16] and WD = memtoreg ? Data : ALUOut.
  - Read during write: A/B capture the pre-write value on the same edge. There is no bypass.
- SignImm = sign-extended Instr[15:0].
- SrcA = alusrca ? A : PC.
- SrcB by alusrcb:
  - 00: B
  - 01: 32'd4
  - 10: SignImm
  - 11: SignImm << 2
- ALU by alucontrol:
  - 010: add
  - 110: sub
  - 000: and
  - 001: or
  - 111: slt, signed, result 32'd1 or 32'd0
  - any other code: result 0
  - Add/sub wrap modulo 2^32. There is no overflow flag.
- PCNext by pcsrc:
  - 00: ALUResult
  - 01: ALUOut
  - 10: {PC[31:28], Instr[25:0], 2'b00}
  - 11: ALUOut (reserved code)
- Outputs:
  - adr = iord ? ALUOut : PC.
  - writedata = B.
- Same-edge interactions:
  - pcen with pcsrc = 00 captures the ALU result computed from the current PC. This is the fetch PC+4 path.
  - irwrite and pcen on the same edge are legal. Instr captures readdata addressed by the old PC.
- No internal state machine sequencing. All sequencing comes from the control inputs; this block guarantees only the single-cycle register semantics above.

Test Plan:
- Reset mid-run:
  - Stimulus: load PC = 32'h40, then pull reset low between edges.
  - Response: PC, adr and op read 0 immediately, before the next edge. Captures stay held while reset is low.
- Fetch:
  - Stimulus: readdata = 32'h0232_8020 (add $16,$17,$18), iord = 0, alusrca = 0, alusrcb = 01, alucontrol = 010, pcsrc = 00, irwrite = 1, pcen = 1, one edge.
  - Response: PC = 4, op = 0, funct = 6'h20.
- R-type execute and write-back:
  - Setup: $17 = 5, $18 = 7.
  - Stimulus: decode edge, then alusrca = 1, alusrcb = 00, alucontrol = 010, then regdst = 1, memtoreg = 0, regwrite = 1.
  - Response: ALUOut = 12, then $16 = 12. With alucontrol = 110, zero = 0; when A = B, sub gives zero = 1.
- lw path:
  - Stimulus: Instr = lw $8,-4($9) with $9 = 32'h100, alusrcb = 10, then iord = 1.
  - Response: adr = 32'hFC. With readdata = 32'hDEAD_BEEF, then memtoreg = 1, regdst = 0, regwrite = 1, $8 = 32'hDEAD_BEEF.
- Branch and jump:
  - beq stimulus: offset 3 at PC = 8 (after fetch PC = 8), alusrcb = 11, then pcsrc = 01 with pcen.
  - beq response: PC = 8 + 12 = 20.
  - j stimulus: Instr = 32'h0800_0010, pcsrc = 10.
  - j response: PC = 32'h40 with PC[31:28] preserved.
- $0 and slt:
  - Stimulus: regwrite to register 0 with WD = 32'hFFFF_FFFF; separately, slt with A = -1, B = 1.
  - Response: reg0 still reads 0. slt gives ALUResult = 1; swapping operands gives 0.

Source files
------------

// File: rtl/mcp_datapath.sv
// Multicycle MIPS datapath: PC, Instr, Data, A, B, ALUOut, register file, ALU and muxes.
// All sequencing comes from the controller's control word; this block only implements per-edge register semantics.
module mcp_datapath #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          REGBITS  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcen,
    input  logic        irwrite,
    input  logic        regwrite,
    input  logic        alusrca,
    input  logic        iord,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic [1:0]  alusrcb,
    input  logic [1:0]  pcsrc,
    input  logic [2:0]  alucontrol,
    input  logic [31:0] readdata,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        zero,
    output logic [31:0] adr,
    output logic [31:0] writedata
);

    localparam int NREGS = 2 ** REGBITS;

    logic [31:0] pc, instr, data, a, b, aluout;
    logic [31:0] rf [NREGS];

    logic [REGBITS-1:0] ra1, ra2, wa;
    logic [31:0]        rd1, rd2, wd;
    logic [31:0]        signimm, srca, srcb, aluresult, pcnext;

    assign ra1 = instr[21 +: REGBITS];
    assign ra2 = instr[16 +: REGBITS];
    assign wa  = regdst ? instr[11 +: REGBITS] : instr[16 +: REGBITS];
    assign wd  = memtoreg ? data : aluout;

    // Register 0 is hardwired to zero on the read side as well as write-protected.
    assign rd1 = (ra1 == '0) ? 32'd0 : rf[ra1];
    assign rd2 = (ra2 == '0) ? 32'd0 : rf[ra2];

    assign signimm = {{16{instr[15]}}, instr[15:0]};
    assign srca    = alusrca ? a : pc;

    always_comb begin
        srcb = b;
        case (alusrcb)
            2'b00: srcb = b;
            2'b01: srcb = 32'd4;
            2'b10: srcb = signimm;
            2'b11: srcb = {signimm[29:0], 2'b00};
            default: srcb = b;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        aluresult = 32'd0;
        case (alucontrol)
            3'b010:  aluresult = srca + srcb;
            3'b110:  aluresult = srca - srcb;
            3'b000:  aluresult = srca & srcb;
            3'b001:  aluresult = srca | srcb;
            3'b111:  aluresult = {31'd0, $signed(srca) < $signed(srcb)};
            default: aluresult = 32'd0;
        endcase
    end

    always_comb begin
        pcnext = aluout;
        case (pcsrc)
            2'b00:   pcnext = aluresult;
            2'b10:   pcnext = {pc[31:28], instr[25:0], 2'b00};
            default: pcnext = aluout;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so A/B see pre-write register values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= PC_RESET;
            instr  <= '0;
            data   <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            if (pcen)    pc    <= pcnext;
            if (irwrite) instr <= readdata;
            data   <= readdata;
            a      <= rd1;
            b      <= rd2;
            aluout <= aluresult;
        end
    end

    // NOTE: the register file is cleared on reset, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (regwrite && (wa != '0)) begin
            rf[wa] <= wd;
        end
    end

    assign op        = instr[31:26];
    assign funct     = instr[5:0];
    assign zero      = (aluresult == 32'd0);
    assign adr       = iord ? aluout : pc;
    assign writedata = b;

endmodule

// File: tb/tb_mcp_datapath.sv
// Directed bench for mcp_datapath: a specification-level model checked every negedge,
// plus hand-computed literal expectations for each scenario.
module tb_mcp_datapath;

    typedef struct packed {
        logic        pcen;
        logic        irwrite;
        logic        regwrite;
        logic        alusrca;
        logic        iord;
        logic        memtoreg;
        logic        regdst;
        logic [1:0]  alusrcb;
        logic [1:0]  pcsrc;
        logic [2:0]  alucontrol;
        logic [31:0] readdata;
    } ctrl_t;

    localparam ctrl_t IDLE = '0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    ctrl_t       cur = IDLE;
    logic [5:0]  op, funct;
    logic        zero;
    logic [31:0] adr, writedata;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // Model state
    logic [31:0] m_pc, m_instr, m_data, m_a, m_b, m_aluout;
    logic [31:0] m_rf [32];

    mcp_datapath dut (
        .clk(clk), .reset(reset),
        .pcen(cur.pcen), .irwrite(cur.irwrite), .regwrite(cur.regwrite),
        .alusrca(cur.alusrca), .iord(cur.iord), .memtoreg(cur.memtoreg),
        .regdst(cur.regdst), .alusrcb(cur.alusrcb), .pcsrc(cur.pcsrc),
        .alucontrol(cur.alucontrol), .readdata(cur.readdata),
        .op(op), .funct(funct), .zero(zero), .adr(adr), .writedata(writedata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_instr = '0; m_data = '0; m_a = '0; m_b = '0; m_aluout = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endtask

    // ALU result the specification requires for the current inputs and model state.
    function automatic logic [31:0] model_res();
        logic [31:0] x, y, simm, r;
        simm = {{16{m_instr[15]}}, m_instr[15:0]};
        x = cur.alusrca ? m_a : m_pc;
        case (cur.alusrcb)
            2'd0:    y = m_b;
            2'd1:    y = 32'd4;
            2'd2:    y = simm;
            default: y = simm * 32'd4;
        endcase
        case (cur.alucontrol)
            3'b010:  r = x + y;
            3'b110:  r = x - y;
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b111:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic apply(input ctrl_t c);
        cur = c;
    endtask

    task automatic step(input ctrl_t c);
        logic [31:0] res, npc, wd, na, nb;
        logic [4:0]  wa;
        apply(c);
        res = model_res();
        case (c.pcsrc)
            2'd0:    npc = res;
            2'd2:    npc = {m_pc[31:28], m_instr[25:0], 2'b00};
            default: npc = m_aluout;
        endcase
        wa = c.regdst ? m_instr[15:11] : m_instr[20:16];
        wd = c.memtoreg ? m_data : m_aluout;
        na = m_rf[m_instr[25:21]];
        nb = m_rf[m_instr[20:16]];
        @(posedge clk);
        if (reset) begin
            if (c.pcen)    m_pc = npc;
            if (c.irwrite) m_instr = c.readdata;
            m_data   = c.readdata;
            m_a      = na;
            m_b      = nb;
            m_aluout = res;
            if (c.regwrite && wa != 5'd0) m_rf[wa] = wd;
        end
        #1;
    endtask

    function automatic ctrl_t ir_load(input logic [31:0] w);
        ctrl_t c = IDLE;
        c.irwrite  = 1'b1;
        c.readdata = w;
        return c;
    endfunction

    function automatic ctrl_t alu_ctl(input logic [2:0] ctl, input logic [1:0] srcb, input logic sa);
        ctrl_t c = IDLE;
        c.alusrca    = sa;
        c.alusrcb    = srcb;
        c.alucontrol = ctl;
        return c;
    endfunction

    task automatic set_instr(input logic [31:0] w);
        step(ir_load(w));
        step(IDLE);
    endtask

    // Writes val into register r through the Data/memtoreg write-back path.
    task automatic load_reg(input logic [4:0] r, input logic [31:0] val);
        ctrl_t c;
        step(ir_load({6'h23, 5'd0, r, 16'h0000}));
        c = IDLE; c.readdata = val; step(c);
        c = IDLE; c.regwrite = 1'b1; c.memtoreg = 1'b1; step(c);
    endtask

    task automatic read_reg(input logic [4:0] r, input logic [31:0] exp, input string name);
        set_instr({6'h2b, 5'd0, r, 16'h0000});
        check(name, writedata, exp);
    endtask

    task automatic peek_aluout(input logic [31:0] exp, input string name);
        ctrl_t c = IDLE;
        c.iord = 1'b1;
        apply(c);
        #1;
        check(name, adr, exp);
    endtask

    // Single compare process: DUT outputs against the model on every negedge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("op",        {26'd0, op},    {26'd0, m_instr[31:26]});
            check("funct",     {26'd0, funct}, {26'd0, m_instr[5:0]});
            check("zero",      {31'd0, zero},  {31'd0, model_res() == 32'd0});
            check("adr",       adr,            cur.iord ? m_aluout : m_pc);
            check("writedata", writedata,      m_b);
        end
    end

    logic [31:0] alu_exp [8];

    initial begin
        ctrl_t c;
        model_reset();
        #2;
        check("rst_adr", adr, 32'd0);
        check("rst_op", {26'd0, op}, 32'd0);
        check("rst_funct", {26'd0, funct}, 32'd0);
        check("rst_wdata", writedata, 32'd0);
        #10 reset = 1'b1;
        chk_en = 1'b1;

        // Jump to 0x40, then reset asynchronously between edges
        step(ir_load(32'h0800_0010));
        c = IDLE; c.pcsrc = 2'd2; c.pcen = 1'b1; step(c);
        check("jump_pc40", adr, 32'h40);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_adr", adr, 32'd0);
        check("async_rst_op", {26'd0, op}, 32'd0);
        c = IDLE; c.irwrite = 1'b1; c.pcen = 1'b1; c.alusrcb = 2'd1;
        c.alucontrol = 3'b010; c.readdata = 32'hFFFF_FFFF;
        step(c);
        check("rst_hold_adr", adr, 32'd0);
        check("rst_hold_op", {26'd0, op}, 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        apply(IDLE);

        // R-type add $16,$17,$18
        load_reg(5'd17, 32'd5);
        load_reg(5'd18, 32'd7);
        c = IDLE; c.irwrite = 1'b1; c.pcen = 1'b1; c.alusrcb = 2'd1;
        c.alucontrol = 3'b010; c.readdata = 32'h0232_8020;
        step(c);
        check("fetch_pc", adr, 32'd4);
        check("fetch_op", {26'd0, op}, 32'd0);
        check("fetch_funct", {26'd0, funct}, 32'h20);
        step(IDLE);
        check("decode_b", writedata, 32'd7);
        apply(alu_ctl(3'b110, 2'd0, 1'b1));
        #1 check("sub_nonzero", {31'd0, zero}, 32'd0);
        step(alu_ctl(3'b010, 2'd0, 1'b1));
        peek_aluout(32'd12, "add_aluout");
        c = IDLE; c.regdst = 1'b1; c.regwrite = 1'b1; step(c);
        read_reg(5'd16, 32'd12, "rtype_wb");
        set_instr({6'h00, 5'd17, 5'd17, 5'd0, 5'd0, 6'h22});
        apply(alu_ctl(3'b110, 2'd0, 1'b1));
        #1 check("sub_zero", {31'd0, zero}, 32'd1);

        // lw $8,-4($9)
        load_reg(5'd9, 32'h100);
        set_instr(32'h8D28_FFFC);
        step(alu_ctl(3'b010, 2'd2, 1'b1));
        peek_aluout(32'hFC, "lw_adr");
        c = IDLE; c.iord = 1'b1; c.readdata = 32'hDEAD_BEEF; step(c);
        c = IDLE; c.regwrite = 1'b1; c.memtoreg = 1'b1; step(c);
        read_reg(5'd8, 32'hDEAD_BEEF, "lw_wb");

        // beq offset 3 fetched at PC=4 -> PC=8, target 20
        c = IDLE; c.irwrite = 1'b1; c.pcen = 1'b1; c.alusrcb = 2'd1;
        c.alucontrol = 3'b010; c.readdata = 32'h1000_0003;
        step(c);
        check("beq_fetch_pc", adr, 32'd8);
        step(alu_ctl(3'b010, 2'd3, 1'b0));
        c = IDLE; c.pcsrc = 2'd1; c.pcen = 1'b1; step(c);
        check("beq_target", adr, 32'd20);

        // Jump preserving PC[31:28]
        load_reg(5'd10, 32'h9000_0000);
        set_instr({6'h00, 5'd10, 5'd0, 16'h0000});
        c = alu_ctl(3'b010, 2'd0, 1'b1); c.pcen = 1'b1; step(c);
        check("pc_high", adr, 32'h9000_0000);
        step(ir_load(32'h0800_0010));
        c = IDLE; c.pcsrc = 2'd2; c.pcen = 1'b1; step(c);
        check("jump_nibble", adr, 32'h9000_0040);

        // $0 stays zero
        load_reg(5'd0, 32'hFFFF_FFFF);
        read_reg(5'd0, 32'd0, "reg0");

        // slt signed, both orders
        load_reg(5'd11, 32'hFFFF_FFFF);
        load_reg(5'd12, 32'd1);
        set_instr({6'h00, 5'd11, 5'd12, 16'h0000});
        step(alu_ctl(3'b111, 2'd0, 1'b1));
        peek_aluout(32'd1, "slt_m1_lt_1");
        set_instr({6'h00, 5'd12, 5'd11, 16'h0000});
        step(alu_ctl(3'b111, 2'd0, 1'b1));
        peek_aluout(32'd0, "slt_1_lt_m1");

        // Every ALU code with A = -1, B = 1
        alu_exp = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd1};
        set_instr({6'h00, 5'd11, 5'd12, 16'h0000});
        for (int k = 0; k < 8; k++) begin
            step(alu_ctl(3'(k), 2'd0, 1'b1));
            peek_aluout(alu_exp[k], $sformatf("alu_code_%0d", k));
            @(negedge clk);
            #1;
        end

        apply(IDLE);
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
